// File: rtl/crossbar_sched.sv
// rtl/crossbar_sched.sv - round-robin burst scheduler driving a crossbar control word
//
// Purpose: arbitrates N_INPUTS requesters round-robin, presents the winner and
// its destination to the crossbar as a control word (valid/ready handshake),
// then counts BURST_LEN beats before releasing the grant.
//
// Optional feature macro: CROSSBAR_SCHED_TIMEOUT_EN
//   defined   - a burst with TIMEOUT consecutive idle cycles is aborted
//   undefined - bursts wait for beats indefinitely, abort is held at 0
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous reset, active high
//   req_val      in   [0:N_INPUTS-1] per-requester burst request
//   req_dest     in   per-requester destination, requester 0 in the MSBs
//   control      out  crossbar control word {winner, dest, zeros}
//   control_val  out  control word valid
//   control_rdy  in   crossbar accepts control word
//   beat_fire    in   one beat moved on the granted path
//   grant_val    out  burst in progress (CFG or XFER)
//   grant_id     out  current winner
//   done         out  one-cycle pulse on burst completion
//   abort        out  one-cycle pulse on timeout abort

module crossbar_sched #(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int BURST_LEN         = 4,
  parameter int TIMEOUT           = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [0:N_INPUTS-1]                    req_val,
  input  logic [N_INPUTS*$clog2(N_OUTPUTS)-1:0]  req_dest,
  output logic [CONTROL_BIT_WIDTH-1:0]           control,
  output logic                                   control_val,
  input  logic                                   control_rdy,
  input  logic                                   beat_fire,
  output logic                                   grant_val,
  output logic [$clog2(N_INPUTS)-1:0]            grant_id,
  output logic                                   done,
  output logic                                   abort
);

  localparam int IW  = $clog2(N_INPUTS);
  localparam int OW  = $clog2(N_OUTPUTS);
  localparam int CBW = CONTROL_BIT_WIDTH;

  localparam logic [7:0]    LP_BURST = 8'(BURST_LEN);
  localparam logic [IW-1:0] LP_LAST  = IW'(N_INPUTS - 1);

`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_winner;
  logic [7:0]        r_beat_cnt;
  logic [CBW-1:0]    r_control;
  logic              r_control_val;
  logic              r_grant_val;
  logic [IW-1:0]     r_grant_id;
  logic              r_done;
  logic              r_abort;
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  logic [TW-1:0]     r_to_cnt;
`endif

  logic              w_found;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_winner;
  logic [OW-1:0]     w_dest;
  logic [CBW-1:0]    w_control;
  logic [IW-1:0]     w_rr_next;
  logic [7:0]        w_beat_next;

  // Round-robin scan starting at r_rr_ptr; first asserted requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_winner = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N_INPUTS);
      if (!w_found && req_val[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Destination field of the winner; requester 0 occupies the top slice.
  always_comb begin
    w_dest = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (w_winner == IW'(i)) begin
        w_dest = req_dest[(N_INPUTS-1-i)*OW +: OW];
      end
    end
  end

  always_comb begin
    w_control                    = '0;
    w_control[CBW-1 -: IW]       = w_winner;
    w_control[CBW-1-IW -: OW]    = w_dest;
  end

  assign w_rr_next   = (r_winner == LP_LAST) ? '0 : r_winner + 1'b1;
  assign w_beat_next = r_beat_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_beat_cnt    <= '0;
      r_control     <= '0;
      r_control_val <= 1'b0;
      r_grant_val   <= 1'b0;
      r_grant_id    <= '0;
      r_done        <= 1'b0;
      r_abort       <= 1'b0;
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner      <= w_winner;
            r_control     <= w_control;
            r_control_val <= 1'b1;
            r_grant_val   <= 1'b1;
            r_grant_id    <= w_winner;
            r_state       <= S_CFG;
          end
        end
        S_CFG: begin
          // Word stays frozen until the crossbar takes it.
          if (control_rdy) begin
            r_control_val <= 1'b0;
            r_control     <= '0;
            r_beat_cnt    <= '0;
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
            r_state       <= S_XFER;
          end
        end
        S_XFER: begin
          if (beat_fire) begin
            r_beat_cnt <= w_beat_next;
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
            if (w_beat_next == LP_BURST) begin
              r_done      <= 1'b1;
              r_grant_val <= 1'b0;
              r_grant_id  <= '0;
              r_rr_ptr    <= w_rr_next;
              r_state     <= S_IDLE;
            end
          end
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
          else if (r_to_cnt == LP_TO_LAST) begin
            r_abort     <= 1'b1;
            r_grant_val <= 1'b0;
            r_grant_id  <= '0;
            r_rr_ptr    <= w_rr_next;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign control     = r_control;
  assign control_val = r_control_val;
  assign grant_val   = r_grant_val;
  assign grant_id    = r_grant_id;
  assign done        = r_done;
  assign abort       = r_abort;

endmodule

// File: tb/tb_crossbar_sched.sv
// tb/tb_crossbar_sched.sv - self-checking bench for crossbar_sched
module tb_crossbar_sched;

  localparam int NI  = 2;
  localparam int NO  = 2;
  localparam int CBW = 42;
  localparam int BL  = 4;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [0:NI-1]   req_val;
  logic [1:0]      req_dest;
  logic [CBW-1:0]  control;
  logic            control_val;
  logic            control_rdy;
  logic            beat_fire;
  logic            grant_val;
  logic [0:0]      grant_id;
  logic            done;
  logic            abort;

  always #5 clk = ~clk;

  crossbar_sched #(
    .N_INPUTS(NI), .N_OUTPUTS(NO), .CONTROL_BIT_WIDTH(CBW),
    .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_dest(req_dest),
    .control(control), .control_val(control_val), .control_rdy(control_rdy),
    .beat_fire(beat_fire), .grant_val(grant_val), .grant_id(grant_id),
    .done(done), .abort(abort)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [CBW-1:0] exp_q[$];

  typedef struct {
    logic [1:0] rv;
    logic [1:0] rd;
    int         bp;
    int         gap;
    bit         stray;
    logic       exp_id;
    logic       exp_dst;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CBW-1:0] ctrl_word(input logic id, input logic dst);
    logic [CBW-1:0] w;
    w = '0;
    w[CBW-1] = id;
    w[CBW-2] = dst;
    return w;
  endfunction

  task automatic pop_check(input string name);
    logic [CBW-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got %0h", name, control);
    end else begin
      e = exp_q.pop_front();
      chk(name, control, e);
    end
  endtask

  // Drive a request from IDLE, check CFG, optional backpressure, enter XFER.
  task automatic start_burst(input logic [1:0] rv, input logic [1:0] rd, input logic eid,
                             input logic edst, input int bp, input bit stray);
    logic [CBW-1:0] held;
    req_val = rv; req_dest = rd; control_rdy = 1'b0; beat_fire = stray;
    exp_q.push_back(ctrl_word(eid, edst));
    tick;
    req_val = '0; req_dest = ~rd;
    chk("cfg_control_val", control_val, 1);
    chk("cfg_grant_val", grant_val, 1);
    chk("cfg_grant_id", grant_id, eid);
    held = control;
    pop_check("cfg_control");
    for (int c = 0; c < bp; c++) begin
      tick;
      chk("bp_control_val", control_val, 1);
      chk("bp_control_stable", control, held);
    end
    control_rdy = 1'b1;
    tick;
    control_rdy = 1'b0; beat_fire = 1'b0;
    chk("xfer_control_val", control_val, 0);
    chk("xfer_grant_val", grant_val, 1);
  endtask

  task automatic run_beats(input int gap, input int n, input bit last_done);
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) tick;
      beat_fire = 1'b1;
      tick;
      beat_fire = 1'b0;
      if (b < n - 1 || !last_done) begin
        chk("mid_done", done, 0);
        chk("mid_grant_val", grant_val, 1);
      end else begin
        chk("done_pulse", done, 1);
        chk("done_grant_val", grant_val, 0);
        chk("done_grant_id", grant_id, 0);
        chk("done_control_val", control_val, 0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{2'b10, 2'b10, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b11, 2'b01, 3, 0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 2'b01, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 2'b10, 0, 2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'b11, 2'b11, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 2'b00, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{2'b01, 2'b01, 0, 0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; req_val = '0; req_dest = '0; control_rdy = 1'b0; beat_fire = 1'b0;
    tick; tick;
    chk("rst_control", control, 0);
    chk("rst_control_val", control_val, 0);
    chk("rst_grant_val", grant_val, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    reset = 1'b0;
    tick;

    for (int r = 0; r < 7; r++) begin
      start_burst(vecs[r].rv, vecs[r].rd, vecs[r].exp_id, vecs[r].exp_dst,
                  vecs[r].bp, vecs[r].stray);
      run_beats(vecs[r].gap, BL, 1'b1);
      tick;
      chk("done_one_cycle", done, 0);
      chk("idle_control_val", control_val, 0);
    end

    // Requests present on the last beat: bubble cycle, then re-arbitrate.
    start_burst(2'b11, 2'b01, 1'b0, 1'b0, 0, 1'b0);
    run_beats(0, BL - 1, 1'b0);
    req_val = 2'b11; req_dest = 2'b01; beat_fire = 1'b1;
    tick;
    beat_fire = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_bubble_control_val", control_val, 0);
    exp_q.push_back(ctrl_word(1'b1, 1'b1));
    tick;
    req_val = '0;
    chk("b2b_done_clear", done, 0);
    chk("b2b_control_val", control_val, 1);
    chk("b2b_grant_id", grant_id, 1);
    pop_check("b2b_control");
    control_rdy = 1'b1;
    tick;
    control_rdy = 1'b0;
    chk("b2b_xfer", control_val, 0);
    run_beats(0, BL, 1'b1);
    tick;

    // Reset mid-burst clears state including the round-robin pointer.
    start_burst(2'b10, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    run_beats(0, BL, 1'b1);
    tick;
    start_burst(2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0);
    run_beats(0, 2, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_grant_val", grant_val, 0);
    chk("mrst_control_val", control_val, 0);
    chk("mrst_done", done, 0);
    tick;
    chk("mrst_no_done", done, 0);
    start_burst(2'b11, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    run_beats(0, BL, 1'b1);
    tick;

    // Idle burst: abort after TIMEOUT cycles, or waits forever without it.
    start_burst(2'b01, 2'b11, 1'b1, 1'b1, 0, 1'b0);
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      tick;
      chk("to_no_abort", abort, 0);
      chk("to_grant_held", grant_val, 1);
    end
    tick;
    chk("to_abort", abort, 1);
    chk("to_grant_val", grant_val, 0);
    tick;
    chk("to_abort_clear", abort, 0);
`else
    for (int c = 0; c < 100; c++) tick;
    chk("nto_grant_val", grant_val, 1);
    chk("nto_abort", abort, 0);
    run_beats(0, BL, 1'b1);
    tick;
`endif
    start_burst(2'b11, 2'b10, 1'b0, 1'b1, 0, 1'b0);
    run_beats(0, BL, 1'b1);
    tick;
    chk("final_idle_grant", grant_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
